// File: rtl/ctrl_sequencer_pkg.sv
// Shared state codes, opcode constants and helpers for the
// accumulator-CPU micro-sequencer.
package ctrl_seq_pkg;

  typedef logic [4:0] state_t;
  typedef logic [2:0] op_t;

  localparam state_t S_RESET = 5'd0;
  localparam state_t S_FETCH = 5'd1;
  localparam state_t S_FRD   = 5'd2;
  localparam state_t S_FXF   = 5'd3;
  localparam state_t S_DEC   = 5'd4;
  localparam state_t S_INC   = 5'd5;
  localparam state_t S_CLA   = 5'd6;
  localparam state_t S_OPA   = 5'd7;
  localparam state_t S_ORD   = 5'd8;
  localparam state_t S_OXF   = 5'd9;
  localparam state_t S_LDW   = 5'd10;
  localparam state_t S_ADW   = 5'd11;
  localparam state_t S_SWR   = 5'd12;
  localparam state_t S_JLD   = 5'd13;
  localparam state_t S_FAULT = 5'd16;

  localparam op_t OP_NOP  = 3'd0;
  localparam op_t OP_INCA = 3'd1;
  localparam op_t OP_CLRA = 3'd2;
  localparam op_t OP_LDA  = 3'd3;
  localparam op_t OP_STA  = 3'd4;
  localparam op_t OP_ADD  = 3'd5;
  localparam op_t OP_JMP  = 3'd6;
  localparam op_t OP_JZ   = 3'd7;

  function automatic logic is_wait(state_t s);
    return (s == S_FRD) || (s == S_ORD) || (s == S_SWR);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Memory-side bus of the sequencer: address select,
// read/write strobes and the completion ack.
interface ctrl_sequencer_if;
  logic mem_rd;
  logic mem_wr;
  logic addr_sel;
  logic mem_ack;

  modport master (
    output mem_rd,
    output mem_wr,
    output addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/ctrl_sequencer_mem_wait_timer.sv
// Cycle counter for memory wait states; flags the last
// cycle allowed before the access is declared dead.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  // TIMEOUT of zero disables the check entirely
  assign expired = (TIMEOUT != 0) &&
                   (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore micro-sequencer for the accumulator CPU: fetch,
// decode, operand access and ACC/PC strobes.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int OPC_W        = 3,
  parameter int TIMEOUT      = 15,
  parameter int ACC_LOAD_LOW = 1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [OPC_W-1:0] opcode,
  input  logic             acc_zero,
  input  logic             run,
  input  logic             step,
  ctrl_sequencer_if.master mem,
  output logic             pc_clr,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             acc_clr,
  output logic             acc_inc,
  output logic             acc_src_alu,
  output logic             acc_load,
  output logic             busy,
  output logic             fault,
  output logic [4:0]       state_dbg
);

  localparam logic LD_IDLE = (ACC_LOAD_LOW != 0);

  state_t state;
  state_t state_n;
  op_t    op_q;
  op_t    dec_op;
  logic   step_pend;
  logic   waiting;
  logic   tmo;
  logic   go;

  // Opcodes wider than 3 bits with any upper bit set are NOPs
  generate
    if (OPC_W > 3) begin : g_wide
      assign dec_op = (|opcode[OPC_W-1:3]) ? OP_NOP
                                           : opcode[2:0];
    end else begin : g_narrow
      assign dec_op = opcode[2:0];
    end
  endgenerate

  assign waiting = is_wait(state);
  assign go      = (state == S_FETCH) && (run || step_pend);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (CLR),
    .clr     (!waiting),
    .en      (waiting && !mem.mem_ack),
    .expired (tmo)
  );

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state     <= S_RESET;
      op_q      <= OP_NOP;
      step_pend <= 1'b0;
    end else begin
      state     <= state_n;
      step_pend <= step || (step_pend && !go);
      if (state == S_DEC)
        op_q <= dec_op;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_RESET: state_n = S_FETCH;
      S_FETCH: if (go) state_n = S_FRD;
      S_FRD: begin
        if (mem.mem_ack)  state_n = S_FXF;
        else if (tmo)     state_n = S_FAULT;
      end
      S_FXF: state_n = S_DEC;
      S_DEC: begin
        unique case (dec_op)
          OP_NOP:  state_n = S_FETCH;
          OP_INCA: state_n = S_INC;
          OP_CLRA: state_n = S_CLA;
          OP_JZ:   state_n = acc_zero ? S_OPA : S_FETCH;
          default: state_n = S_OPA;
        endcase
      end
      S_INC: state_n = S_FETCH;
      S_CLA: state_n = S_FETCH;
      S_OPA: begin
        unique case (op_q)
          OP_LDA,
          OP_ADD:  state_n = S_ORD;
          OP_STA:  state_n = S_SWR;
          default: state_n = S_JLD;
        endcase
      end
      S_ORD: begin
        if (mem.mem_ack)  state_n = S_OXF;
        else if (tmo)     state_n = S_FAULT;
      end
      S_OXF: state_n = (op_q == OP_ADD) ? S_ADW : S_LDW;
      S_LDW: state_n = S_FETCH;
      S_ADW: state_n = S_FETCH;
      S_SWR: begin
        if (mem.mem_ack)  state_n = S_FETCH;
        else if (tmo)     state_n = S_FAULT;
      end
      S_JLD:   state_n = S_FETCH;
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_RESET;
    endcase
  end

  always_comb begin
    pc_clr       = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    mem.addr_sel = 1'b0;
    mem.mem_rd   = 1'b0;
    mem.mem_wr   = 1'b0;
    acc_clr      = 1'b0;
    acc_inc      = 1'b0;
    acc_src_alu  = 1'b0;
    acc_load     = LD_IDLE;
    busy         = 1'b1;
    fault        = 1'b0;
    unique case (state)
      S_RESET: pc_clr = 1'b1;
      S_FETCH: busy = 1'b0;
      S_FRD:   mem.mem_rd = 1'b1;
      S_FXF:   mdr_load = 1'b1;
      S_DEC: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      S_INC:   acc_inc = 1'b1;
      S_CLA:   acc_clr = 1'b1;
      S_OPA:   mem.addr_sel = 1'b1;
      S_ORD: begin
        mem.addr_sel = 1'b1;
        mem.mem_rd   = 1'b1;
      end
      S_OXF: begin
        mem.addr_sel = 1'b1;
        mdr_load     = 1'b1;
      end
      S_LDW:   acc_load = !LD_IDLE;
      S_ADW: begin
        acc_src_alu = 1'b1;
        acc_load    = !LD_IDLE;
      end
      S_SWR: begin
        mem.addr_sel = 1'b1;
        mem.mem_wr   = 1'b1;
      end
      S_JLD:   pc_load = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized instruction-level check of ctrl_sequencer against
// an expected per-cycle trace expanded from each instruction.
module tb_ctrl_sequencer;
  import ctrl_seq_pkg::*;

  localparam int TMO = 4;

  typedef struct packed {
    logic pc_clr;
    logic pc_inc;
    logic pc_load;
    logic ir_load;
    logic mdr_load;
    logic addr_sel;
    logic mem_rd;
    logic mem_wr;
    logic acc_clr;
    logic acc_inc;
    logic acc_src_alu;
    logic acc_load;
    logic busy;
    logic fault;
  } outs_t;

  typedef struct {
    logic [4:0] st;
    logic       ack;
    logic       run;
    logic       step;
    logic [3:0] opc;
    logic       az;
  } ent_t;

  logic       clk = 1'b0;
  logic       CLR;
  logic [3:0] opcode;
  logic       acc_zero;
  logic       run;
  logic       step;
  logic       pc_clr, pc_inc, pc_load, ir_load, mdr_load;
  logic       acc_clr, acc_inc, acc_src_alu, acc_load;
  logic       busy, fault;
  logic [4:0] state_dbg;

  int   tests = 0;
  int   fails = 0;
  ent_t q[$];
  bit   faulted;

  ctrl_sequencer_if bus ();

  ctrl_sequencer #(
    .OPC_W        (4),
    .TIMEOUT      (TMO),
    .ACC_LOAD_LOW (1)
  ) dut (
    .clk         (clk),
    .CLR         (CLR),
    .opcode      (opcode),
    .acc_zero    (acc_zero),
    .run         (run),
    .step        (step),
    .mem         (bus.master),
    .pc_clr      (pc_clr),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .ir_load     (ir_load),
    .mdr_load    (mdr_load),
    .acc_clr     (acc_clr),
    .acc_inc     (acc_inc),
    .acc_src_alu (acc_src_alu),
    .acc_load    (acc_load),
    .busy        (busy),
    .fault       (fault),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe pattern each named state must show
  function automatic outs_t spec_outs(logic [4:0] s);
    outs_t o;
    o = '0;
    o.acc_load = 1'b1;
    o.busy     = 1'b1;
    case (s)
      S_RESET: o.pc_clr = 1'b1;
      S_FETCH: o.busy = 1'b0;
      S_FRD:   o.mem_rd = 1'b1;
      S_FXF:   o.mdr_load = 1'b1;
      S_DEC:   begin o.ir_load = 1'b1; o.pc_inc = 1'b1; end
      S_INC:   o.acc_inc = 1'b1;
      S_CLA:   o.acc_clr = 1'b1;
      S_OPA:   o.addr_sel = 1'b1;
      S_ORD:   begin o.addr_sel = 1'b1; o.mem_rd = 1'b1; end
      S_OXF:   begin o.addr_sel = 1'b1; o.mdr_load = 1'b1; end
      S_LDW:   o.acc_load = 1'b0;
      S_ADW:   begin o.acc_src_alu = 1'b1; o.acc_load = 1'b0; end
      S_SWR:   begin o.addr_sel = 1'b1; o.mem_wr = 1'b1; end
      S_JLD:   o.pc_load = 1'b1;
      S_FAULT: o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t dut_outs();
    return {pc_clr, pc_inc, pc_load, ir_load, mdr_load,
            bus.addr_sel, bus.mem_rd, bus.mem_wr, acc_clr,
            acc_inc, acc_src_alu, acc_load, busy, fault};
  endfunction

  function automatic void add(logic [4:0] st, logic ack,
                              logic r, logic s,
                              logic [3:0] opc, logic az);
    ent_t e;
    e.st = st; e.ack = ack; e.run = r;
    e.step = s; e.opc = opc; e.az = az;
    q.push_back(e);
  endfunction

  // A cycle whose don't-care inputs are randomized
  function automatic void add_any(logic [4:0] st);
    add(st, 1'($urandom), 1'($urandom), 1'b0,
        4'($urandom), 1'($urandom));
  endfunction

  // Wait state acked in cycle w (1..TMO); w==0 never acks
  function automatic bit add_wait(logic [4:0] st, int w);
    int n = (w == 0) ? TMO : w;
    for (int i = 1; i <= n; i++)
      add(st, (w != 0) && (i == n), 1'($urandom), 1'b0,
          4'($urandom), 1'($urandom));
    if (w == 0) begin
      repeat (3) add_any(S_FAULT);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void build(int op, bit az, int w0, int w1,
                                bit stepm, int idle);
    int dop = (op > 7) ? 0 : op;
    faulted = 1'b0;
    if (!stepm) begin
      add(S_FETCH, 1'($urandom), 1'b1, 1'b0,
          4'($urandom), 1'($urandom));
    end else begin
      repeat (idle)
        add(S_FETCH, 1'($urandom), 1'b0, 1'b0,
            4'($urandom), 1'($urandom));
      add(S_FETCH, 1'($urandom), 1'b0, 1'b1,
          4'($urandom), 1'($urandom));
      add(S_FETCH, 1'($urandom), 1'b0, 1'b0,
          4'($urandom), 1'($urandom));
    end
    if (!add_wait(S_FRD, w0)) begin
      faulted = 1'b1;
      return;
    end
    add_any(S_FXF);
    add(S_DEC, 1'($urandom), 1'($urandom), 1'b0, 4'(op), az);
    case (dop)
      1: add_any(S_INC);
      2: add_any(S_CLA);
      3, 5: begin
        add_any(S_OPA);
        if (!add_wait(S_ORD, w1)) begin
          faulted = 1'b1;
          return;
        end
        add_any(S_OXF);
        add_any((dop == 5) ? S_ADW : S_LDW);
      end
      4: begin
        add_any(S_OPA);
        if (!add_wait(S_SWR, w1)) faulted = 1'b1;
      end
      6: begin add_any(S_OPA); add_any(S_JLD); end
      7: if (az) begin add_any(S_OPA); add_any(S_JLD); end
      default: ;
    endcase
  endfunction

  task automatic do_clr();
    CLR = 1'b1;
    run = 1'b0; step = 1'b0; bus.mem_ack = 1'b0;
    #2;
    check("clr_state", 32'(state_dbg), 32'(S_RESET));
    check("clr_outs", 32'(dut_outs()), 32'(spec_outs(S_RESET)));
    CLR = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_trace(int clr_at);
    ent_t e;
    for (int i = 0; i < q.size(); i++) begin
      if (i == clr_at) begin
        do_clr();
        q.delete();
        return;
      end
      e = q[i];
      run = e.run; step = e.step; opcode = e.opc;
      acc_zero = e.az; bus.mem_ack = e.ack;
      check("state", 32'(state_dbg), 32'(e.st));
      check("outs", 32'(dut_outs()), 32'(spec_outs(e.st)));
      @(posedge clk); #1;
    end
    q.delete();
    if (faulted) do_clr();
  endtask

  task automatic instr(int op, bit az, int w0, int w1,
                       bit stepm, int idle, int clr_at);
    build(op, az, w0, w1, stepm, idle);
    run_trace(clr_at);
  endtask

  initial begin
    int op, ca;
    CLR = 1'b1; run = 1'b0; step = 1'b0;
    opcode = '0; acc_zero = 1'b0; bus.mem_ack = 1'b0;
    #3;
    check("rst_state", 32'(state_dbg), 32'(S_RESET));
    check("rst_outs", 32'(dut_outs()), 32'(spec_outs(S_RESET)));
    CLR = 1'b0;
    @(posedge clk); #1;
    check("rst_exit", 32'(state_dbg), 32'(S_FETCH));

    instr(1, 0, 1, 1, 0, 0, -1);
    instr(7, 0, 1, 1, 0, 0, -1);
    instr(7, 1, 1, 1, 0, 0, -1);
    instr(5, 0, 1, 4, 0, 0, -1);
    instr(4, 0, 1, 0, 0, 0, -1);
    instr(4, 0, 1, 4, 0, 0, -1);
    instr(3, 0, 1, 3, 0, 0, 6);
    instr(0, 0, 2, 1, 1, 3, -1);
    instr(2, 0, 1, 1, 1, 2, -1);
    instr(12, 0, 1, 1, 0, 0, -1);
    instr(6, 0, 3, 1, 0, 0, -1);
    instr(3, 0, 0, 1, 0, 0, -1);

    for (int n = 0; n < 150; n++) begin
      op = ($urandom % 8 == 0) ? $urandom_range(8, 15)
                               : $urandom_range(0, 7);
      build(op, 1'($urandom),
            ($urandom % 10 == 0) ? 0 : $urandom_range(1, TMO),
            ($urandom % 10 == 0) ? 0 : $urandom_range(1, TMO),
            ($urandom % 3 == 0), $urandom_range(0, 3));
      ca = ($urandom % 8 == 0) ? $urandom_range(0, q.size() - 1)
                               : -1;
      run_trace(ca);
    end

    run = 1'b0; step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("park_state", 32'(state_dbg), 32'(S_FETCH));
    check("park_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
